cnt_bcd_display: RTL and testbench

Downstream consumer of the 8-bit free-running counter value (cnt). It samples the count on a load strobe and converts it to 3-digit BCD with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. It flags counter wrap-around between successive samples. It time-multiplexes the last converted value onto a 3-digit 7-segment display.

---
 rtl/cnt_bcd_display.sv | 149 ++++++++++++++
 tb/tb_cnt_bcd_display.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cnt_bcd_display.sv
// Samples an 8-bit count, converts it to 3-digit BCD with a bit-serial double-dabble engine,
// flags wrap-around between samples and scans the result onto a 3-digit 7-segment display.
module cnt_bcd_display #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cnt_in,
    input  logic        load,
    output logic        busy,
    output logic        bcd_valid,
    output logic [11:0] bcd,
    output logic        wrap,
    output logic [2:0]  an,
    output logic [6:0]  seg
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [15:0] DivLast = 16'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [7:0]  sample_q, shift_q, prev_q;
    logic [11:0] scratch_q, scratch_next, bcd_q;
    logic [2:0]  bit_cnt_q;
    logic        valid_q, wrap_q;
    logic        accept, shifting, last;
    logic [15:0] div_q;
    logic [1:0]  digit_q;
    logic [2:0]  an_q;
    logic [6:0]  seg_q;
    logic [3:0]  digit_val;
    logic        blank;
    logic [6:0]  seg_d;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (load) state_d = StShift;
            StShift: if (bit_cnt_q == 3'd7) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StShift);
        accept   = (state_q == StIdle) && load;
        shifting = (state_q == StShift);
        last     = shifting && (bit_cnt_q == 3'd7);
    end

    // Adjust every digit first, then shift in the next sample bit.
    always_comb begin
        scratch_next = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        scratch_next = {scratch_next[10:0], shift_q[7]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q  <= '0;
            shift_q   <= '0;
            prev_q    <= '0;
            scratch_q <= '0;
            bit_cnt_q <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            if (accept) begin
                sample_q  <= cnt_in;
                shift_q   <= cnt_in;
                scratch_q <= '0;
                bit_cnt_q <= '0;
            end else if (shifting) begin
                shift_q   <= {shift_q[6:0], 1'b0};
                scratch_q <= scratch_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (last) begin
                    bcd_q   <= scratch_next;
                    valid_q <= 1'b1;
                    wrap_q  <= (sample_q < prev_q);
                    prev_q  <= sample_q;
                end
            end
        end
    end

    always_comb begin
        unique case (digit_q)
            2'd1:    begin digit_val = bcd_q[7:4];  blank = (bcd_q[11:4] == 8'h00); end
            2'd2:    begin digit_val = bcd_q[11:8]; blank = (bcd_q[11:8] == 4'h0);  end
            default: begin digit_val = bcd_q[3:0];  blank = 1'b0;                   end
        endcase
        seg_d = blank ? 7'h00 : seg7(digit_val);
    end

    // an/seg follow the digit index one cycle later, so every digit lags terminal count equally.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            digit_q <= '0;
            an_q    <= 3'b001;
            seg_q   <= 7'h3F;
        end else begin
            if (div_q == DivLast) begin
                div_q   <= '0;
                digit_q <= (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
            end else begin
                div_q <= div_q + 16'd1;
            end
            an_q  <= 3'b001 << digit_q;
            seg_q <= seg_d;
        end
    end

    assign bcd_valid = valid_q;
    assign bcd       = bcd_q;
    assign wrap      = wrap_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_cnt_bcd_display.sv
// Directed plus randomized bench for cnt_bcd_display, checked every cycle against an
// arithmetic reference model of conversion latency, wrap detection and display scanning.
module tb_cnt_bcd_display;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cnt_in = '0;
    logic        load = 1'b0;
    logic        busy, bcd_valid, wrap;
    logic [11:0] bcd;
    logic [2:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    cnt_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .load      (load),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd       (bcd),
        .wrap      (wrap),
        .an        (an),
        .seg       (seg)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (plain integers)
    int m_left = 0;
    int m_pend = 0;
    int m_prev = 0;
    int m_val  = 0;
    int m_val_prev = 0;
    int m_valid = 0;
    int m_wrap = 0;
    int m_k = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int seg_lut(input int d);
        case (d)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            7: return 'h07;
            8: return 'h7F;
            default: return 'h6F;
        endcase
    endfunction

    function automatic int seg_of(input int v, input int dig);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (dig == 0) return seg_lut(o);
        if (dig == 1) return (h == 0 && t == 0) ? 0 : seg_lut(t);
        return (h == 0) ? 0 : seg_lut(h);
    endfunction

    task automatic cycle(input bit r, input bit ld, input int val);
        int dig;
        rst    = r;
        load   = ld;
        cnt_in = 8'(val);
        @(posedge clk);
        if (r) begin
            m_left = 0; m_prev = 0; m_val = 0; m_val_prev = 0;
            m_valid = 0; m_wrap = 0; m_k = 0;
        end else begin
            m_val_prev = m_val;
            m_k++;
            m_valid = 0;
            m_wrap  = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1;
                    m_val   = m_pend;
                    m_wrap  = (m_pend < m_prev) ? 1 : 0;
                    m_prev  = m_pend;
                end
            end else if (ld) begin
                m_pend = val % 256;
                m_left = 8;
            end
        end
        @(negedge clk);
        dig = (m_k == 0) ? 0 : ((m_k - 1) / SCAN_DIV) % 3;
        check_eq("busy", int'(busy), (m_left > 0) ? 1 : 0);
        check_eq("bcd_valid", int'(bcd_valid), m_valid);
        check_eq("wrap", int'(wrap), m_wrap);
        check_eq("bcd", int'(bcd), to_bcd(m_val));
        check_eq("an", int'(an), 1 << dig);
        check_eq("seg", int'(seg), seg_of(m_val_prev, dig));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
    endtask

    initial begin
        int v;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
        // Full-scale conversion
        cycle(1'b0, 1'b1, 255); idle(10);
        // Load during busy is ignored; later 42 wraps against 137
        cycle(1'b0, 1'b1, 137); idle(2); cycle(1'b0, 1'b1, 42); idle(8);
        cycle(1'b0, 1'b1, 42); idle(9);
        // Wrap then equal value; second load lands in the bcd_valid cycle
        cycle(1'b0, 1'b1, 250); idle(8);
        cycle(1'b0, 1'b1, 3); idle(7);
        cycle(1'b0, 1'b1, 3); idle(9);
        // Scan and blanking
        cycle(1'b0, 1'b1, 7); idle(20);
        cycle(1'b0, 1'b1, 105); idle(20);
        cycle(1'b0, 1'b1, 100); idle(20);
        // Abort mid-conversion, then a clean retry
        cycle(1'b0, 1'b1, 200); idle(3); cycle(1'b1, 1'b0, 0);
        idle(2); cycle(1'b0, 1'b1, 200); idle(20);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 15));
                1:       v = int'($urandom_range(100, 109));
                default: v = int'($urandom_range(0, 255));
            endcase
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), v);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
